psum_accumulator: RTL
=====================

# psum_accumulator

Downstream consumer of the IPF multiply engine. It takes the 32 per-lane 72-bit partial-product buses (`tmp_result0..31`, flattened) whenever `res_valid` is high. Each lane's eight signed 9-bit products are reduced to one lane sum. Lane sums are accumulated across the weight rounds required by the kernel size (3×3: 1 round, 5×5: 2, 7×7: 4), and 32 signed output pixels are presented with a one-cycle `acc_valid` strobe. It sits between IPF and the output write-back buffer.

## Interface
Parameters:
- `LANES`, 32, number of lanes (one per IPF `tmp_result` bus)
- `PROD_N`, 8, products per lane
- `PROD_W`, 9, signed product width (matches IPF `Out_Width`)
- `ACC_W`, 16, signed accumulator width per lane; must be ≥ PROD_W+5

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `res_valid`  in  1  IPF result strobe; `tmp_result` is valid this cycle
- `tmp_result`  in  LANES*PROD_N*PROD_W  lane k occupies bits [72k+71:72k]; product j of a lane occupies [9j+8:9j]
- `Wsize`  in  2  0 = 3×3, 1 = 5×5, 2 = 7×7, 3 = reserved (treated as 0)
- `flush`  in  1  synchronous abort of the group in progress
- `acc_valid`  out  1  one-cycle strobe; `acc_data` holds a completed group
- `acc_data`  out  LANES*ACC_W  lane k at [ACC_W*k+ACC_W-1 : ACC_W*k], signed
- `round_cnt`  out  2  rounds accumulated so far in the current group
- `busy`  out  1  high while a group is partially accumulated or the pipeline holds data

## Operation
- Stage 1 (reduce): on an edge sampling `res_valid`=1:
  - each lane's 8 products are sign-extended and summed into a 12-bit signed lane sum, which is registered;
  - `sum_v` is set; otherwise `sum_v` is cleared.
- Stage 2 (accumulate): on an edge with `sum_v`=1:
  - the new value is acc_new = (round_cnt==0 ? 0 : acc) + sign-extended lane sum;
  - `round_cnt` is incremented.
- Rounds per group R: Wsize 0→1, 1→2, 2→4, 3→1.
  - R is latched when stage 2 consumes the first round of a group (round_cnt==0).
  - Changes to `Wsize` mid-group are ignored until the next group.
- FSM states:
  - IDLE (round_cnt=0, no partial sum). On `sum_v`: go to DONE-in-one-step if R==1, else go to ACCUM.
  - ACCUM. On `sum_v` with round_cnt+1 < R: stay in ACCUM. On `sum_v` with round_cnt+1 == R: finish the group and go to IDLE.
- Finishing a group:
  - `acc_data` ← acc_new, `acc_valid` ← 1, `round_cnt` ← 0;
  - the internal accumulator is cleared for the next group.
- Gaps: any number of idle cycles (IPF hold periods) are allowed between rounds; the accumulator holds.
- Arithmetic: two's complement, no saturation. Width rule PROD_W+3+2 ≤ ACC_W guarantees no overflow.
- `flush` has priority over all other activity:
  - next edge clears `sum_v`, the accumulator, `round_cnt` and `acc_valid`;
  - any `res_valid` in the same cycle is discarded;
  - `acc_data` retains its last completed value.
- `busy` = `sum_v` | (round_cnt≠0).

## Timing
- Reset values: `acc_valid`=0, `acc_data`=0, `round_cnt`=0, `busy`=0; internal `sum_v` and accumulator are 0.
- Latency: final-round `res_valid` sampled at edge E0 → `acc_valid` high for exactly the cycle after E1 (2 clocks).
- Throughput: one `res_valid` per cycle indefinitely.
  - Back-to-back groups need no bubble: the final round of group n and the first round of group n+1 on consecutive cycles are both accepted.
  - The next group's first round overwrites rather than adds.
- `acc_data` is stable from the `acc_valid` cycle until the next group completes. There is no backpressure; the consumer must capture on the strobe.
- `rst` mid-group: all state cleared on that edge. Data sampled in the same cycle as `rst` is discarded.
- `flush` asserted in the cycle a final-round `sum_v` would complete: the group is discarded, and no `acc_valid` is produced.

## Test plan
- Reset and idle: hold `rst` 2 cycles, then idle → `acc_valid`=0, `acc_data`=0, `busy`=0 throughout.
- 3×3 single round:
  - Stimulus: Wsize=0; one `res_valid` with every product of lane 0 = +3 and every product of lane 31 = −256 (9'h100).
  - Response: 2 cycles later `acc_valid` pulses once; lane 0 = 24, lane 31 = −2048.
- 5×5 with a hold gap:
  - Stimulus: Wsize=1; round 1 all products = 1; 5 idle cycles; round 2 all products = 2.
  - Response: `round_cnt` reads 1 during the gap; a single strobe follows, with every lane = 24.
- 7×7 worst case:
  - Stimulus: Wsize=2; 4 consecutive rounds with all products = 255 (max positive).
  - Response: every lane = 8160 with no wrap.
  - Repeat with all products = −256 → every lane = −8192.
- Back-to-back groups with flush:
  - Stimulus: Wsize=0; 3 consecutive `res_valid` with all products 1, 2, 3.
  - Response: 3 consecutive strobes carrying 8, 16, 24.
  - Then, with Wsize=1: round 1, then `flush` together with round 2 → no strobe, `acc_data` stays 24, `round_cnt`=0.
- Reset mid-group: Wsize=2, 2 rounds, `rst` → next group of 4 rounds with all products = 1 gives 32, not 48.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: reduces the 32 per-lane IPF partial-product buses into
// lane sums and accumulates them over the 1/2/4 weight rounds a 3x3/5x5/7x7
// kernel needs, then presents 32 signed pixels with a one-cycle acc_valid.
//
// Pipeline: stage 1 registers the reduced lane sums (sum_v), stage 2 adds
// them into the per-lane accumulator. Final-round res_valid at edge E0
// gives acc_valid high in the cycle after E1.
//
// Handshake: res_valid is a pure strobe with no ready. Every cycle with
// res_valid high is accepted unless rst or flush is high in that cycle.
// acc_valid is a one-cycle strobe with no backpressure. acc_data stays
// stable until the next group completes.
module psum_accumulator #(
  parameter int LANES  = 32,
  parameter int PROD_N = 8,
  parameter int PROD_W = 9,
  parameter int ACC_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             res_valid,
  input  logic [LANES*PROD_N*PROD_W-1:0]   tmp_result,
  input  logic [1:0]                       Wsize,
  input  logic                             flush,
  output logic                             acc_valid,
  output logic [LANES*ACC_W-1:0]           acc_data,
  output logic [1:0]                       round_cnt,
  output logic                             busy
);

  // Lane sum wide enough for PROD_N signed products without overflow.
  localparam int SUM_W = PROD_W + $clog2(PROD_N);

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t                          state;
  state_t                          state_next;

  logic [LANES-1:0][SUM_W-1:0]     lane_sum_c;
  logic [LANES-1:0][SUM_W-1:0]     lane_sum_q;
  logic                            sum_v;

  logic [LANES-1:0][ACC_W-1:0]     acc_q;
  logic [LANES-1:0][ACC_W-1:0]     acc_new_c;
  logic [LANES-1:0][ACC_W-1:0]     acc_data_q;

  logic [2:0]                      r_decode;
  logic [2:0]                      r_lat;
  logic [2:0]                      r_eff;
  logic [2:0]                      cnt_inc;
  logic                            first_round;
  logic                            finish;

  // Stage 1 reduce: sign-extend each lane's products and add them up.
  always_comb begin
    lane_sum_c = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < PROD_N; j++) begin
        lane_sum_c[k] = lane_sum_c[k]
          + {{(SUM_W-PROD_W){tmp_result[(k*PROD_N+j)*PROD_W+PROD_W-1]}},
             tmp_result[(k*PROD_N+j)*PROD_W +: PROD_W]};
      end
    end
  end

  // Stage 1 register: capture lane sums; rst/flush drop any sample this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_v      <= 1'b0;
      lane_sum_q <= '0;
    end else if (flush) begin
      sum_v      <= 1'b0;
    end else begin
      sum_v <= res_valid;
      if (res_valid) begin
        lane_sum_q <= lane_sum_c;
      end
    end
  end

  // Round count per group; reserved Wsize value behaves like 3x3.
  always_comb begin
    r_decode = 3'd1;
    case (Wsize)
      2'd1:    r_decode = 3'd2;
      2'd2:    r_decode = 3'd4;
      default: r_decode = 3'd1;
    endcase
  end

  // Next-state and stage 2 arithmetic. The first round of a group uses the
  // live Wsize and overwrites the accumulator; later rounds use the latched R.
  always_comb begin
    first_round = (round_cnt == 2'd0);
    r_eff       = first_round ? r_decode : r_lat;
    cnt_inc     = {1'b0, round_cnt} + 3'd1;
    finish      = sum_v && (cnt_inc == r_eff);
    state_next  = state;
    if (sum_v) begin
      state_next = (cnt_inc == r_eff) ? S_IDLE : S_ACCUM;
    end
    acc_new_c = '0;
    for (int k = 0; k < LANES; k++) begin
      acc_new_c[k] = (first_round ? {ACC_W{1'b0}} : acc_q[k])
        + {{(ACC_W-SUM_W){lane_sum_q[k][SUM_W-1]}}, lane_sum_q[k]};
    end
  end

  // FSM state register; rst and flush both abandon the current group.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Stage 2 datapath: accumulate, count rounds, publish a finished group.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      round_cnt  <= 2'd0;
      r_lat      <= 3'd1;
      acc_data_q <= '0;
      acc_valid  <= 1'b0;
    end else if (flush) begin
      acc_q      <= '0;
      round_cnt  <= 2'd0;
      acc_valid  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (sum_v) begin
        if (finish) begin
          acc_data_q <= acc_new_c;
          acc_valid  <= 1'b1;
          acc_q      <= '0;
          round_cnt  <= 2'd0;
        end else begin
          acc_q     <= acc_new_c;
          round_cnt <= cnt_inc[1:0];
          if (first_round) begin
            r_lat <= r_decode;
          end
        end
      end
    end
  end

  assign acc_data = acc_data_q;
  assign busy     = sum_v | (round_cnt != 2'd0);

endmodule
